// File: rtl/memory_controller.sv
// Single-port word storage with a wait-state sequencer and one-cycle done pulse.
// Optional MEMORY_ALIGN_CHECK_EN rejects misaligned or out-of-range addresses with fault.
module memory_controller #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        read_req,
    input  logic        write_req,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        fault
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 is_wr_q, is_wr_d;
    logic                 fault_q, fault_d;
    logic                 req;
    logic                 reject;
    logic                 unused_addr;

    assign req = read_req | write_req;

`ifdef MEMORY_ALIGN_CHECK_EN
    assign reject      = (address[1:0] != 2'b00) || (address[31:ADDR_BITS+2] != '0);
    assign unused_addr = 1'b0;
`else
    assign reject      = 1'b0;
    assign unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd1) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                if (!is_wr_q) rdata_d = mem[idx_q];
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        // The DONE exit edge is already free for the next request: one access per W+2 cycles.
        if ((state_q == S_IDLE || state_q == S_DONE) && req) begin
            idx_d   = address[ADDR_BITS+1:2];
            wdata_d = data_in;
            is_wr_d = write_req;
            cnt_d   = WAIT_LD;
            if (reject) begin
                state_d = S_DONE;
                fault_d = 1'b1;
            end else if (WAIT_LD != 4'd0) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_ACCESS;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
            fault_q <= fault_d;
        end
    end

    // Storage has no reset; contents survive clr.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && is_wr_q) mem[idx_q] <= wdata_q;
    end

    assign data_out = rdata_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign fault    = fault_q;
endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: two instances (W=2 and W=0) sharing clk and clr.
module tb_memory_controller;
    logic        clk;
    logic        clr;
    logic [31:0] addr2, din2, dout2, addr0, din0, dout0;
    logic        rr2, wr2, busy2, done2, fault2;
    logic        rr0, wr0, busy0, done0, fault0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model2 [int];
    logic [31:0] model0 [int];

    memory_controller #(.ADDR_BITS(9), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .clr(clr), .address(addr2), .data_in(din2),
        .read_req(rr2), .write_req(wr2), .data_out(dout2),
        .busy(busy2), .done(done2), .fault(fault2));

    memory_controller #(.ADDR_BITS(9), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .clr(clr), .address(addr0), .data_in(din0),
        .read_req(rr0), .write_req(wr0), .data_out(dout0),
        .busy(busy0), .done(done0), .fault(fault0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h1FF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request so that it is sampled on the next rising edge (E0); returns 1ns after E0.
    task automatic issue2(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        wr2 = wr; rr2 = rd; addr2 = a; din2 = d;
        if (wr) model2[widx(a)] = d;
        else if (rd) exp_q.push_back(model2.exists(widx(a)) ? model2[widx(a)] : 32'h0);
        tick();
        wr2 = 1'b0; rr2 = 1'b0;
    endtask

    task automatic issue0(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        wr0 = wr; rr0 = rd; addr0 = a; din0 = d;
        if (wr) model0[widx(a)] = d;
        else if (rd) exp_q.push_back(model0.exists(widx(a)) ? model0[widx(a)] : 32'h0);
        tick();
        wr0 = 1'b0; rr0 = 1'b0;
    endtask

    // Returns k such that done is first seen after edge E0+k, or -1 on timeout.
    task automatic wait_done2(input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (done2) begin cyc = k; break; end
        end
    endtask

    task automatic wait_done0(input int max, output int cyc);
        cyc = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (done0) begin cyc = k; break; end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick(); tick();
        checks++; if (dout2 !== 32'h0 || busy2 !== 1'b0 || done2 !== 1'b0 || fault2 !== 1'b0) begin
            errors++; $display("FAIL reset_w2: dout=%h busy=%b done=%b fault=%b expected 0/0/0/0", dout2, busy2, done2, fault2); end
        clr = 1'b0;
        tick();
        checks++; if (dout0 !== 32'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || fault0 !== 1'b0) begin
            errors++; $display("FAIL reset_w0: dout=%h busy=%b done=%b fault=%b expected 0/0/0/0", dout0, busy0, done0, fault0); end
    endtask

    task automatic test_write_read_w2();
        int cyc;
        logic [31:0] exp;
        issue2(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL w2_busy_after_e0: got %b expected 1", busy2); end
        wait_done2(10, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL w2_write_latency: got %0d expected 3", cyc); end
        issue2(1'b0, 1'b1, 32'h10, 32'h0);
        checks++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin
            errors++; $display("FAIL w2_read_start: busy=%b done=%b expected 1/0", busy2, done2); end
        wait_done2(10, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL w2_read_latency: got %0d expected 3", cyc); end
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL w2_read_data: got %h expected %h", dout2, exp); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL w2_busy_in_done: got %b expected 1", busy2); end
        tick();
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++; $display("FAIL w2_after_done: busy=%b done=%b expected 0/0", busy2, done2); end
    endtask

    task automatic test_w0_priority();
        int cyc;
        logic [31:0] exp;
        issue0(1'b1, 1'b0, 32'h24, 32'h11111111);
        wait_done0(5, cyc);
        issue0(1'b0, 1'b1, 32'h24, 32'h0);
        wait_done0(5, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL w0_read_latency: got %0d expected 1", cyc); end
        exp = exp_q.pop_front();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL w0_read_data: got %h expected %h", dout0, exp); end
        issue0(1'b1, 1'b1, 32'h20, 32'h12345678);
        wait_done0(5, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL w0_both_latency: got %0d expected 1", cyc); end
        checks++; if (dout0 !== 32'h11111111) begin
            errors++; $display("FAIL w0_write_keeps_dout: got %h expected 11111111", dout0); end
        issue0(1'b0, 1'b1, 32'h20, 32'h0);
        wait_done0(5, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL w0_write_won: got %h expected %h", dout0, exp); end
        tick();
    endtask

    task automatic test_ignored_req();
        int pulses;
        int cyc;
        logic [31:0] exp;
        pulses = 0;
        issue2(1'b1, 1'b0, 32'h30, 32'h0BADF00D);
        rr2 = 1'b1; addr2 = 32'h10;
        tick();
        rr2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done2) pulses++;
            tick();
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignored_req_pulses: got %0d expected 1", pulses); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ignored_req_idle: busy=%b expected 0", busy2); end
        issue2(1'b0, 1'b1, 32'h30, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL ignored_req_write: got %h expected %h", dout2, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int pulses;
        logic [31:0] exp;
        pulses = 0;
        issue2(1'b1, 1'b0, 32'h40, 32'h1);
        wait_done2(10, cyc);
        wr2 = 1'b1; addr2 = 32'h40; din2 = 32'h2;
        tick();
        wr2 = 1'b0;
        tick();
        clr = 1'b1;
        #1;
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || dout2 !== 32'h0 || fault2 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs: busy=%b done=%b dout=%h fault=%b expected 0", busy2, done2, dout2, fault2); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done2) pulses++;
        end
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done2) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", pulses); end
        issue2(1'b0, 1'b1, 32'h40, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL reset_mid_write_aborted: got %h expected %h", dout2, exp); end
        tick();
    endtask

`ifndef MEMORY_ALIGN_CHECK_EN
    task automatic test_alias();
        int cyc;
        logic [31:0] exp;
        issue2(1'b1, 1'b0, 32'h810, 32'hCAFE0001);
        wait_done2(10, cyc);
        checks++; if (fault2 !== 1'b0) begin errors++; $display("FAIL alias_no_fault: got %b expected 0", fault2); end
        issue2(1'b0, 1'b1, 32'h010, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL alias_upper: got %h expected %h", dout2, exp); end
        issue2(1'b0, 1'b1, 32'h013, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL alias_low_bits: got %h expected %h", dout2, exp); end
        tick();
    endtask
`else
    task automatic test_fault();
        int cyc;
        logic [31:0] exp;
        issue2(1'b1, 1'b0, 32'h14, 32'hAAAA5555);
        wait_done2(10, cyc);
        issue2(1'b1, 1'b0, 32'h10, 32'h00000055);
        wait_done2(10, cyc);
        issue2(1'b0, 1'b1, 32'h14, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL fault_setup: got %h expected %h", dout2, exp); end
        tick();
        rr2 = 1'b1; addr2 = 32'h013;
        tick();
        rr2 = 1'b0;
        checks++; if (done2 !== 1'b1 || fault2 !== 1'b1) begin
            errors++; $display("FAIL fault_read: done=%b fault=%b expected 1/1", done2, fault2); end
        checks++; if (dout2 !== 32'hAAAA5555) begin errors++; $display("FAIL fault_read_dout: got %h expected aaaa5555", dout2); end
        tick();
        checks++; if (fault2 !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL fault_clear: fault=%b busy=%b expected 0/0", fault2, busy2); end
        wr2 = 1'b1; addr2 = 32'h810; din2 = 32'h99999999;
        tick();
        wr2 = 1'b0;
        checks++; if (done2 !== 1'b1 || fault2 !== 1'b1) begin
            errors++; $display("FAIL fault_write: done=%b fault=%b expected 1/1", done2, fault2); end
        tick();
        issue2(1'b0, 1'b1, 32'h010, 32'h0);
        wait_done2(10, cyc);
        exp = exp_q.pop_front();
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL fault_write_blocked: got %h expected %h", dout2, exp); end
        tick();
    endtask
`endif

    initial begin
        clr = 1'b1;
        rr2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
        rr0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
        test_reset();
        test_write_read_w2();
        test_w0_priority();
        test_ignored_req();
        test_reset_mid();
`ifndef MEMORY_ALIGN_CHECK_EN
        test_alias();
`else
        test_fault();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
